// File: rtl/mem_ctrl.sv
// Byte-serial RAM front end: arbitrates LSB loads/stores and instruction fetches onto an
// 8-bit single-port RAM, with a direct-mapped, one-word-per-line instruction cache.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int ICACHE_IDX = 4,
  parameter int ICACHE_EN  = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_clear_up,
  output logic                  ram_rw,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_in,
  input  logic [7:0]            ram_out,
  input  logic                  lsb_valid,
  input  logic                  lsb_is_store,
  input  logic [2:0]            lsb_op,
  input  logic [31:0]           lsb_addr,
  input  logic [31:0]           lsb_data,
  output logic                  lsb_done,
  output logic [31:0]           lsb_data_out,
  input  logic                  fetch_valid,
  input  logic [31:0]           fetch_pc,
  output logic                  fetch_ready,
  output logic [31:0]           inst,
  output logic [31:0]           inst_addr,
  output logic [1:0]            dbg_state
);

  // Handshake: a requester raises its valid and holds it, unchanged, until the matching
  // one-cycle done/ready pulse; it must drop valid in that pulse cycle, since the edge
  // ending the pulse cycle is an IDLE edge that samples requests again.
  localparam int DEPTH = 1 << ICACHE_IDX;
  localparam int TAG_W = 32 - ICACHE_IDX - 2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_LOAD = 2'd2, S_STORE = 2'd3} state_t;

  state_t                  state_q;
  logic [2:0]              step_q, nbytes_q, op_q;
  logic [31:0]             addr_q, wdata_q, buf_q;
  logic                    ram_rw_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;
  logic [7:0]              ram_in_q;
  logic                    done_q, ready_q;
  logic [31:0]             data_out_q, inst_q, inst_addr_q;
  logic [DEPTH-1:0]        valid_q;
  logic [TAG_W-1:0]        tag_q [DEPTH];
  logic [31:0]             line_q [DEPTH];

  logic [ICACHE_IDX-1:0]   fidx, sidx, aidx;
  logic [TAG_W-1:0]        ftag, stag, atag;
  logic                    fhit, shit;
  logic [2:0]              req_bytes, step_nx;
  logic [31:0]             next_addr, word_d;

  assign fidx      = fetch_pc[ICACHE_IDX+1:2];
  assign ftag      = fetch_pc[31:ICACHE_IDX+2];
  assign sidx      = lsb_addr[ICACHE_IDX+1:2];
  assign stag      = lsb_addr[31:ICACHE_IDX+2];
  assign aidx      = addr_q[ICACHE_IDX+1:2];
  assign atag      = addr_q[31:ICACHE_IDX+2];
  assign fhit      = (ICACHE_EN != 0) && valid_q[fidx] && (tag_q[fidx] == ftag);
  assign shit      = valid_q[sidx] && (tag_q[sidx] == stag);
  assign step_nx   = step_q + 3'd1;
  assign next_addr = addr_q + {29'd0, step_nx};

  always_comb begin
    req_bytes = 3'd4;
    case (lsb_op[1:0])
      2'd0:    req_bytes = 3'd1;
      2'd1:    req_bytes = 3'd2;
      default: req_bytes = 3'd4;
    endcase
  end

  // Reads are pipelined: at step s the byte addressed at step s-1 is on ram_out.
  always_comb begin
    word_d = buf_q;
    case (step_q)
      3'd1:    word_d[7:0]   = ram_out;
      3'd2:    word_d[15:8]  = ram_out;
      3'd3:    word_d[23:16] = ram_out;
      3'd4:    word_d[31:24] = ram_out;
      default: word_d = buf_q;
    endcase
  end

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] op);
    case (op[1:0])
      2'd0:    extend = op[2] ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      2'd1:    extend = op[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      step_q      <= 3'd0;
      nbytes_q    <= 3'd0;
      op_q        <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      ram_rw_q    <= 1'b1;
      ram_addr_q  <= '0;
      ram_in_q    <= 8'd0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      data_out_q  <= 32'd0;
      inst_q      <= 32'd0;
      inst_addr_q <= 32'd0;
      valid_q     <= '0;
    end else if (rdy_in) begin
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rob_clear_up && lsb_valid) begin
            addr_q     <= lsb_addr;
            op_q       <= lsb_op;
            wdata_q    <= lsb_data;
            nbytes_q   <= req_bytes;
            step_q     <= 3'd0;
            ram_addr_q <= lsb_addr[ADDR_WIDTH-1:0];
            if (lsb_is_store) begin
              state_q  <= S_STORE;
              ram_rw_q <= 1'b0;
              ram_in_q <= lsb_data[7:0];
              if (shit) valid_q[sidx] <= 1'b0;
            end else begin
              state_q <= S_LOAD;
            end
          end else if (!rob_clear_up && fetch_valid) begin
            if (fhit) begin
              ready_q     <= 1'b1;
              inst_q      <= line_q[fidx];
              inst_addr_q <= fetch_pc;
            end else begin
              state_q    <= S_FETCH;
              addr_q     <= fetch_pc;
              nbytes_q   <= 3'd4;
              step_q     <= 3'd0;
              ram_addr_q <= fetch_pc[ADDR_WIDTH-1:0];
            end
          end
        end
        S_FETCH, S_LOAD: begin
          if (rob_clear_up) begin
            state_q <= S_IDLE;
          end else if (step_q == nbytes_q) begin
            state_q <= S_IDLE;
            if (state_q == S_LOAD) begin
              done_q     <= 1'b1;
              data_out_q <= extend(word_d, op_q);
            end else begin
              ready_q     <= 1'b1;
              inst_q      <= word_d;
              inst_addr_q <= addr_q;
              if (ICACHE_EN != 0) begin
                line_q[aidx]  <= word_d;
                tag_q[aidx]   <= atag;
                valid_q[aidx] <= 1'b1;
              end
            end
          end else begin
            buf_q  <= word_d;
            step_q <= step_nx;
            if (step_nx < nbytes_q) ram_addr_q <= next_addr[ADDR_WIDTH-1:0];
          end
        end
        S_STORE: begin
          // Stores are already committed, so a flush does not stop them.
          if (step_nx == nbytes_q) begin
            state_q  <= S_IDLE;
            ram_rw_q <= 1'b1;
            done_q   <= 1'b1;
          end else begin
            step_q     <= step_nx;
            ram_addr_q <= next_addr[ADDR_WIDTH-1:0];
            ram_in_q   <= wdata_q[15:8];
            wdata_q    <= {8'd0, wdata_q[31:8]};
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ram_rw       = ram_rw_q | ~rdy_in;
  assign ram_addr     = ram_addr_q;
  assign ram_in       = ram_in_q;
  assign lsb_done     = done_q;
  assign lsb_data_out = data_out_q;
  assign fetch_ready  = ready_q;
  assign inst         = inst_q;
  assign inst_addr    = inst_addr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-addressed RAM model, reference memory and cache-residency model,
// directed scenarios followed by randomized loads, stores and fetches.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear_up;
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [7:0]  ram_in, ram_out;
  logic        lsb_valid, lsb_is_store;
  logic [2:0]  lsb_op;
  logic [31:0] lsb_addr, lsb_data;
  logic        lsb_done;
  logic [31:0] lsb_data_out;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic [31:0] inst, inst_addr;
  logic [1:0]  dbg_state;

  mem_ctrl #(.ADDR_WIDTH(32), .ICACHE_IDX(4), .ICACHE_EN(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear_up(rob_clear_up),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_in(ram_in), .ram_out(ram_out),
    .lsb_valid(lsb_valid), .lsb_is_store(lsb_is_store), .lsb_op(lsb_op),
    .lsb_addr(lsb_addr), .lsb_data(lsb_data), .lsb_done(lsb_done),
    .lsb_data_out(lsb_data_out), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .inst(inst), .inst_addr(inst_addr), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- RAM model and write log ----------------
  logic [7:0]  mem [1024];
  logic [7:0]  ref_mem [1024];
  logic        ram_init;
  logic [31:0] seed;
  logic [23:0] wr_q[$];
  logic [23:0] exp_q[$];
  int          wr_rd;
  int          mdl_line[int];
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [7:0] init_byte(input int a, input logic [31:0] s);
    logic [31:0] h;
    h = (32'(a) * 32'h9E3779B1) ^ s;
    case (a)
      'h100: return 8'h13;
      'h101: return 8'h05;
      'h102: return 8'h00;
      'h103: return 8'h00;
      'h200: return 8'h80;
      'h201: return 8'hFF;
      default: return h[23:16];
    endcase
  endfunction

  always @(posedge clk_in) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_byte(i, seed);
      ram_out <= 8'h00;
    end else begin
      if (ram_rw === 1'b0) begin
        mem[ram_addr[9:0]] <= ram_in;
        wr_q.push_back({ram_addr[15:0], ram_in});
      end
      ram_out <= mem[ram_addr[9:0]];
    end
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] op);
    return (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < n; i++) v = v + (32'(ref_mem[(a + 32'(i)) & 32'h3FF]) << (8 * i));
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
    int n;
    logic [31:0] v;
    n = nbytes(op);
    v = ref_word(a, n);
    if (!op[2] && n < 4 && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ram_rw"}, 32'(ram_rw), 32'd1);
    check({tag, "_ram_addr"}, ram_addr, 32'd0);
    check({tag, "_ram_in"}, 32'(ram_in), 32'd0);
    check({tag, "_lsb_done"}, 32'(lsb_done), 32'd0);
    check({tag, "_fetch_ready"}, 32'(fetch_ready), 32'd0);
    check({tag, "_data_out"}, lsb_data_out, 32'd0);
    check({tag, "_inst"}, inst, 32'd0);
    check({tag, "_inst_addr"}, inst_addr, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic check_writes(input string tag);
    logic [23:0] e, got;
    check({tag, "_wr_count"}, 32'(wr_q.size() - wr_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (wr_rd < wr_q.size()) ? wr_q[wr_rd] : 24'hxxxxxx;
      wr_rd++;
      check({tag, "_wr"}, 32'(got), 32'(e));
    end
    wr_rd = wr_q.size();
  endtask

  // ---------------- drivers ----------------
  task automatic wait_pulse(input bit want_fetch, output int lat);
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if ((want_fetch ? fetch_ready : lsb_done) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] op, output logic [31:0] res);
    int lat;
    lsb_valid = 1'b1; lsb_is_store = 1'b0; lsb_op = op; lsb_addr = a;
    wait_pulse(1'b0, lat);
    lsb_valid = 1'b0;
    res = lsb_data_out;
    check($sformatf("ld_lat_%h_op%0d", a, op), 32'(lat), 32'(nbytes(op) + 1));
    check($sformatf("ld_data_%h_op%0d", a, op), res, ref_load(a, op));
  endtask

  // mode 0: plain, 1: flush mid-store, 2: rdy_in low for 3 cycles mid-store
  task automatic do_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d,
                          input int mode);
    int n, lat, w;
    n = nbytes(op);
    w = int'(a & ~32'd3);
    if (mdl_line.exists(line_of(a)) && mdl_line[line_of(a)] == w) mdl_line.delete(line_of(a));
    for (int i = 0; i < n; i++) begin
      ref_mem[(a + 32'(i)) & 32'h3FF] = 8'(d >> (8 * i));
      exp_q.push_back({16'(a + 32'(i)), 8'(d >> (8 * i))});
    end
    lsb_valid = 1'b1; lsb_is_store = 1'b1; lsb_op = op; lsb_addr = a; lsb_data = d;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      rob_clear_up = 1'b0;
      if (lsb_done === 1'b1) begin
        lat = k;
        break;
      end
      if (k == 1 && mode == 1) rob_clear_up = 1'b1;
      if (k == 1 && mode == 2) begin
        rdy_in = 1'b0;
        for (int p = 0; p < 3; p++) begin
          #1 check($sformatf("pause_rw_%0d", p), 32'(ram_rw), 32'd1);
          @(negedge clk_in);
        end
        rdy_in = 1'b1;
        k += 3;
      end
    end
    lsb_valid = 1'b0; lsb_is_store = 1'b0;
    check($sformatf("st_lat_%h_m%0d", a, mode), 32'(lat), 32'(n + ((mode == 2) ? 3 : 0)));
    check_writes($sformatf("st_%h", a));
  endtask

  task automatic do_fetch(input logic [31:0] pc);
    int lat;
    bit hit;
    logic [31:0] a0;
    hit = mdl_line.exists(line_of(pc)) && mdl_line[line_of(pc)] == int'(pc);
    a0 = ram_addr;
    fetch_valid = 1'b1; fetch_pc = pc;
    wait_pulse(1'b1, lat);
    fetch_valid = 1'b0;
    check($sformatf("fe_lat_%h", pc), 32'(lat), hit ? 32'd0 : 32'd5);
    check($sformatf("fe_inst_%h", pc), inst, ref_word(pc, 4));
    check($sformatf("fe_addr_%h", pc), inst_addr, pc);
    if (hit) check($sformatf("fe_hit_noram_%h", pc), ram_addr, a0);
    if (lat >= 0) mdl_line[line_of(pc)] = int'(pc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] res, a, d;
    logic [2:0]  op;
    int kd, kf, nr, r;
    logic [2:0] ld_ops [5];
    ld_ops[0] = 3'd0; ld_ops[1] = 3'd1; ld_ops[2] = 3'd2; ld_ops[3] = 3'd4; ld_ops[4] = 3'd5;

    rst_in = 1'b1; rdy_in = 1'b1; rob_clear_up = 1'b0;
    lsb_valid = 1'b0; lsb_is_store = 1'b0; lsb_op = 3'd0; lsb_addr = 0; lsb_data = 0;
    fetch_valid = 1'b0; fetch_pc = 0;
    ram_init = 1'b1; seed = $urandom; wr_rd = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i, seed);
    repeat (4) @(negedge clk_in);
    check_reset("reset");
    rst_in = 1'b0; ram_init = 1'b0;
    @(negedge clk_in);
    wr_rd = wr_q.size();

    // cold fetch then hit
    do_fetch(32'h100);
    check("cold_inst_const", inst, 32'h00000513);
    do_fetch(32'h100);

    // sign / zero extension
    do_load(32'h200, 3'd1, res);
    check("lh_const", res, 32'hFFFFFF80);
    do_load(32'h200, 3'd5, res);
    check("lhu_const", res, 32'h0000FF80);
    do_load(32'h201, 3'd0, res);
    check("lb_const", res, 32'hFFFFFFFF);

    // simultaneous LW and fetch: LSB wins, fetch accepted at the edge ending lsb_done
    lsb_valid = 1'b1; lsb_is_store = 1'b0; lsb_op = 3'd2; lsb_addr = 32'h204;
    fetch_valid = 1'b1; fetch_pc = 32'h104;
    kd = -1; kf = -1; res = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_in);
      if (lsb_done === 1'b1 && kd < 0) begin
        kd = k; res = lsb_data_out; lsb_valid = 1'b0;
      end
      if (fetch_ready === 1'b1) begin
        kf = k; fetch_valid = 1'b0;
        break;
      end
    end
    check("arb_lsb_lat", 32'(kd), 32'd5);
    check("arb_fetch_lat", 32'(kf), 32'd11);
    check("arb_lw_data", res, ref_word(32'h204, 4));
    check("arb_inst", inst, ref_word(32'h104, 4));
    if (kf >= 0) mdl_line[line_of(32'h104)] = 'h104;

    // store invalidates a cached line
    do_fetch(32'h100);
    do_store(32'h100, 3'd2, 32'h00100093, 0);
    do_fetch(32'h100);
    check("inval_inst_const", inst, 32'h00100093);

    // flush in cycle 2 of a fetch miss
    fetch_valid = 1'b1; fetch_pc = 32'h108;
    nr = 0;
    repeat (2) begin
      @(negedge clk_in);
      if (fetch_ready === 1'b1) nr++;
    end
    rob_clear_up = 1'b1; fetch_valid = 1'b0;
    @(negedge clk_in);
    rob_clear_up = 1'b0;
    repeat (8) begin
      if (fetch_ready === 1'b1) nr++;
      @(negedge clk_in);
    end
    check("flush_no_ready", 32'(nr), 32'd0);
    check("flush_idle", 32'(dbg_state), 32'd0);
    do_fetch(32'h108);

    // flush during a store and pause during a store
    do_store(32'h120, 3'd2, $urandom, 1);
    do_store(32'h124, 3'd2, $urandom, 2);
    do_load(32'h124, 3'd2, res);

    // reset in the middle of a load clears the cache
    lsb_valid = 1'b1; lsb_is_store = 1'b0; lsb_op = 3'd2; lsb_addr = 32'h208;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1; lsb_valid = 1'b0;
    @(negedge clk_in);
    check_reset("midrst");
    rst_in = 1'b0;
    mdl_line.delete();
    do_fetch(32'h100);

    // randomized traffic over two aliasing 64-byte blocks
    repeat (60) begin
      r = $urandom_range(0, 2);
      a = 32'h300 + 32'(4 * $urandom_range(0, 31));
      if (r == 0) begin
        op = ld_ops[$urandom_range(0, 4)];
        if (op[1:0] == 2'd0) a = a + 32'($urandom_range(0, 3));
        if (op[1:0] == 2'd1) a = a + 32'(2 * $urandom_range(0, 1));
        do_load(a, op, res);
      end else if (r == 1) begin
        op = 3'($urandom_range(0, 2));
        if (op[1:0] == 2'd0) a = a + 32'($urandom_range(0, 3));
        if (op[1:0] == 2'd1) a = a + 32'(2 * $urandom_range(0, 1));
        d = $urandom;
        do_store(a, op, d, 0);
      end else begin
        do_fetch(a);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
